// File: rtl/regfile_pkg.sv
// Shared constants and pair-operation encoding for the register file.
package regfile_pkg;

  localparam int unsigned DATASIZE_DEF = 8;
  localparam int unsigned REGBIT_DEF   = 3;

  typedef enum logic [1:0] {
    POP_NONE,
    POP_WRITE,
    POP_INC,
    POP_DEC
  } pair_op_e;

endpackage

// File: rtl/regfile_ext_register.sv
// Single storage element: load-enabled register with synchronous active-low reset.
module register #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (en) q_d = d;
  end

  always_ff @(posedge clk) begin
    if (!rst) q_q <= '0;
    else      q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/regfile_ext.sv
// Register file with byte writes, 16-bit pair write/inc/dec, flag register and two read ports.
// Define REGFILE_BYPASS_EN to forward same-edge write results onto the read ports.
module regfile_ext
  import regfile_pkg::*;
#(
  parameter int unsigned DATASIZE = DATASIZE_DEF,
  parameter int unsigned REGBIT   = REGBIT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wrenb,
  input  logic [REGBIT-1:0]     waddr,
  input  logic [DATASIZE-1:0]   wdata,
  input  logic                  pwenb,
  input  logic                  incenb,
  input  logic                  decenb,
  input  logic [REGBIT-2:0]     paddr,
  input  logic [2*DATASIZE-1:0] pdata,
  output logic [2*DATASIZE-1:0] pdout,
  output logic                  pzero,
  input  logic                  flenb,
  input  logic [DATASIZE-1:0]   flmask,
  input  logic [DATASIZE-1:0]   ifdat,
  output logic [DATASIZE-1:0]   ofdat,
  input  logic                  r1enb,
  input  logic                  r2enb,
  input  logic [REGBIT-1:0]     r1add,
  input  logic [REGBIT-1:0]     r2add,
  output logic [DATASIZE-1:0]   r1dat,
  output logic [DATASIZE-1:0]   r2dat
);

  localparam int unsigned NREG = 2 ** REGBIT;
  localparam int unsigned PW   = 2 * DATASIZE;

  logic [DATASIZE-1:0] reg_q [NREG];
  logic [DATASIZE-1:0] reg_d [NREG];
  logic [NREG-1:0]     reg_en;

  pair_op_e          pair_op;
  logic [REGBIT-1:0] hi_idx;
  logic [REGBIT-1:0] lo_idx;
  logic [PW-1:0]     pair_val;
  logic [PW-1:0]     pair_res;

  logic [DATASIZE-1:0] flag_d, flag_q;
  logic [DATASIZE-1:0] r1dat_d, r1dat_q;
  logic [DATASIZE-1:0] r2dat_d, r2dat_q;
  logic                pzero_d, pzero_q;

  assign hi_idx   = {paddr, 1'b0};
  assign lo_idx   = {paddr, 1'b1};
  assign pair_val = {reg_q[hi_idx], reg_q[lo_idx]};
  assign pdout    = pair_val;

  always_comb begin
    pair_op = POP_NONE;
    if (pwenb)       pair_op = POP_WRITE;
    else if (incenb) pair_op = POP_INC;
    else if (decenb) pair_op = POP_DEC;
  end

  always_comb begin
    pair_res = pair_val;
    pzero_d  = 1'b0;
    case (pair_op)
      POP_WRITE: pair_res = pdata;
      POP_INC:   pair_res = pair_val + PW'(1);
      POP_DEC:   pair_res = pair_val - PW'(1);
      default:   pair_res = pair_val;
    endcase
    if (pair_op == POP_INC || pair_op == POP_DEC) pzero_d = (pair_res == '0);
  end

  // Pair operation is applied after the byte write so it wins on a shared register.
  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      reg_d[i]  = reg_q[i];
      reg_en[i] = 1'b0;
      if (wrenb && waddr == REGBIT'(i)) begin
        reg_d[i]  = wdata;
        reg_en[i] = 1'b1;
      end
      if (pair_op != POP_NONE && hi_idx == REGBIT'(i)) begin
        reg_d[i]  = pair_res[PW-1:DATASIZE];
        reg_en[i] = 1'b1;
      end
      if (pair_op != POP_NONE && lo_idx == REGBIT'(i)) begin
        reg_d[i]  = pair_res[DATASIZE-1:0];
        reg_en[i] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : reg_block
    register #(.WIDTH(DATASIZE)) u_reg (
      .clk (clk),
      .rst (rst),
      .en  (reg_en[g]),
      .d   (reg_d[g]),
      .q   (reg_q[g])
    );
  end

  always_comb begin
    flag_d = flag_q;
    if (flenb) flag_d = (flag_q & ~flmask) | (ifdat & flmask);
  end

  always_comb begin
    r1dat_d = r1dat_q;
    r2dat_d = r2dat_q;
`ifdef REGFILE_BYPASS_EN
    if (r1enb) r1dat_d = reg_en[r1add] ? reg_d[r1add] : reg_q[r1add];
    if (r2enb) r2dat_d = reg_en[r2add] ? reg_d[r2add] : reg_q[r2add];
`else
    if (r1enb) r1dat_d = reg_q[r1add];
    if (r2enb) r2dat_d = reg_q[r2add];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      flag_q  <= '0;
      r1dat_q <= '0;
      r2dat_q <= '0;
      pzero_q <= 1'b0;
    end else begin
      flag_q  <= flag_d;
      r1dat_q <= r1dat_d;
      r2dat_q <= r2dat_d;
      pzero_q <= pzero_d;
    end
  end

  assign ofdat = flag_q;
  assign r1dat = r1dat_q;
  assign r2dat = r2dat_q;
  assign pzero = pzero_q;

endmodule

// File: tb/tb_regfile_ext.sv
// Self-checking bench for regfile_ext: directed scenarios plus randomized traffic against a reference model.
module tb_regfile_ext;

  logic        clk = 1'b0;
  logic        rst;
  logic        wrenb;
  logic [2:0]  waddr;
  logic [7:0]  wdata;
  logic        pwenb, incenb, decenb;
  logic [1:0]  paddr;
  logic [15:0] pdata;
  logic [15:0] pdout;
  logic        pzero;
  logic        flenb;
  logic [7:0]  flmask, ifdat, ofdat;
  logic        r1enb, r2enb;
  logic [2:0]  r1add, r2add;
  logic [7:0]  r1dat, r2dat;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] m_regs [8];
  logic [7:0] m_flag, m_r1, m_r2;
  logic       m_pz;

  regfile_ext #(.DATASIZE(8), .REGBIT(3)) dut (
    .clk(clk), .rst(rst),
    .wrenb(wrenb), .waddr(waddr), .wdata(wdata),
    .pwenb(pwenb), .incenb(incenb), .decenb(decenb),
    .paddr(paddr), .pdata(pdata), .pdout(pdout), .pzero(pzero),
    .flenb(flenb), .flmask(flmask), .ifdat(ifdat), .ofdat(ofdat),
    .r1enb(r1enb), .r2enb(r2enb), .r1add(r1add), .r2add(r2add),
    .r1dat(r1dat), .r2dat(r2dat)
  );

  always #5 clk = ~clk;

  task automatic idle();
    rst = 1'b1; wrenb = 0; waddr = '0; wdata = '0;
    pwenb = 0; incenb = 0; decenb = 0; paddr = '0; pdata = '0;
    flenb = 0; flmask = '0; ifdat = '0;
    r1enb = 0; r2enb = 0; r1add = '0; r2add = '0;
  endtask

  // Reference model: pair treated as a 16-bit number, byte write first then pair op overrides.
  task automatic tick();
    logic [7:0]  nregs [8];
    logic [7:0]  nflag, nr1, nr2;
    logic [15:0] pv, pres;
    logic        act, pz;
    int          hi, lo;
    for (int i = 0; i < 8; i++) nregs[i] = m_regs[i];
    nflag = m_flag; nr1 = m_r1; nr2 = m_r2; pz = 0;
    if (!rst) begin
      for (int i = 0; i < 8; i++) nregs[i] = 8'h00;
      nflag = 0; nr1 = 0; nr2 = 0;
    end else begin
      hi = int'(paddr) * 2;
      lo = hi + 1;
      pv = {m_regs[hi], m_regs[lo]};
      act = 1; pres = pv;
      if (pwenb)       pres = pdata;
      else if (incenb) begin pres = pv + 16'd1; pz = (pres == 16'd0); end
      else if (decenb) begin pres = pv - 16'd1; pz = (pres == 16'd0); end
      else             act = 0;
      if (wrenb) nregs[waddr] = wdata;
      if (act) begin nregs[hi] = pres[15:8]; nregs[lo] = pres[7:0]; end
      if (flenb) nflag = (m_flag & ~flmask) | (ifdat & flmask);
`ifdef REGFILE_BYPASS_EN
      if (r1enb) nr1 = nregs[r1add];
      if (r2enb) nr2 = nregs[r2add];
`else
      if (r1enb) nr1 = m_regs[r1add];
      if (r2enb) nr2 = m_regs[r2add];
`endif
    end
    @(posedge clk);
    for (int i = 0; i < 8; i++) m_regs[i] = nregs[i];
    m_flag = nflag; m_r1 = nr1; m_r2 = nr2; m_pz = pz;
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle(); rst = 1'b0;
    tick(); tick();
    idle();
    for (int p = 0; p < 4; p++) begin
      paddr = 2'(p); #1;
      n_cmp++;
      if (pdout !== 16'h0000) begin n_fail++; $display("FAIL reset_pair%0d got %h want 0000", p, pdout); end
    end
    n_cmp++; if (ofdat !== 8'h00) begin n_fail++; $display("FAIL reset_flag got %h want 00", ofdat); end
    n_cmp++; if (r1dat !== 8'h00) begin n_fail++; $display("FAIL reset_r1 got %h want 00", r1dat); end
    n_cmp++; if (r2dat !== 8'h00) begin n_fail++; $display("FAIL reset_r2 got %h want 00", r2dat); end
    n_cmp++; if (pzero !== 1'b0) begin n_fail++; $display("FAIL reset_pzero got %b want 0", pzero); end
  endtask

  task automatic test_byte_write();
    idle(); wrenb = 1; waddr = 3'd0; wdata = 8'hAA;
    tick();
    idle(); r1enb = 1; r1add = 3'd0;
    tick();
    idle(); paddr = 2'd0; #1;
    n_cmp++; if (r1dat !== 8'hAA) begin n_fail++; $display("FAIL byte_write_r1 got %h want AA", r1dat); end
    n_cmp++; if (pdout !== 16'hAA00) begin n_fail++; $display("FAIL byte_write_reg1 got %h want AA00", pdout); end
  endtask

  task automatic test_pair_inc();
    idle(); pwenb = 1; paddr = 2'd1; pdata = 16'h12FF; tick();
    n_cmp++; if (pzero !== 1'b0) begin n_fail++; $display("FAIL pwrite_pzero got %b want 0", pzero); end
    idle(); incenb = 1; paddr = 2'd1; tick();
    n_cmp++; if (pdout !== 16'h1300) begin n_fail++; $display("FAIL inc_carry got %h want 1300", pdout); end
    n_cmp++; if (pzero !== 1'b0) begin n_fail++; $display("FAIL inc_pzero0 got %b want 0", pzero); end
    idle(); pwenb = 1; paddr = 2'd1; pdata = 16'hFFFF; tick();
    idle(); incenb = 1; paddr = 2'd1; tick();
    n_cmp++; if (pdout !== 16'h0000) begin n_fail++; $display("FAIL inc_wrap got %h want 0000", pdout); end
    n_cmp++; if (pzero !== 1'b1) begin n_fail++; $display("FAIL inc_pzero1 got %b want 1", pzero); end
    idle(); paddr = 2'd1; tick();
    n_cmp++; if (pzero !== 1'b0) begin n_fail++; $display("FAIL pzero_pulse got %b want 0", pzero); end
  endtask

  task automatic test_pair_dec();
    idle(); pwenb = 1; paddr = 2'd0; pdata = 16'h0000; tick();
    idle(); decenb = 1; paddr = 2'd0; tick();
    n_cmp++; if (pdout !== 16'hFFFF) begin n_fail++; $display("FAIL dec_wrap got %h want FFFF", pdout); end
    n_cmp++; if (pzero !== 1'b0) begin n_fail++; $display("FAIL dec_pzero got %b want 0", pzero); end
    idle(); pwenb = 1; decenb = 1; incenb = 1; paddr = 2'd0; pdata = 16'h1234; tick();
    n_cmp++; if (pdout !== 16'h1234) begin n_fail++; $display("FAIL pw_priority got %h want 1234", pdout); end
    idle(); incenb = 1; decenb = 1; paddr = 2'd0; tick();
    n_cmp++; if (pdout !== 16'h1235) begin n_fail++; $display("FAIL inc_priority got %h want 1235", pdout); end
    idle(); pwenb = 1; paddr = 2'd0; pdata = 16'h0001; tick();
    idle(); decenb = 1; paddr = 2'd0; tick();
    n_cmp++; if (pzero !== 1'b1) begin n_fail++; $display("FAIL dec_pzero1 got %b want 1", pzero); end
  endtask

  task automatic test_flags();
    idle(); flenb = 1; flmask = 8'hFF; ifdat = 8'h00; tick();
    idle(); flenb = 1; flmask = 8'h0F; ifdat = 8'hFF; tick();
    n_cmp++; if (ofdat !== 8'h0F) begin n_fail++; $display("FAIL flag_set got %h want 0F", ofdat); end
    idle(); flenb = 1; flmask = 8'h05; ifdat = 8'h00; tick();
    n_cmp++; if (ofdat !== 8'h0A) begin n_fail++; $display("FAIL flag_clr got %h want 0A", ofdat); end
    idle(); flmask = 8'hFF; ifdat = 8'hFF; tick();
    n_cmp++; if (ofdat !== 8'h0A) begin n_fail++; $display("FAIL flag_hold got %h want 0A", ofdat); end
  endtask

  task automatic test_read_collision();
    logic [7:0] exp;
    idle(); wrenb = 1; waddr = 3'd3; wdata = 8'h11; tick();
    idle(); wrenb = 1; waddr = 3'd3; wdata = 8'h55; r2enb = 1; r2add = 3'd3; tick();
`ifdef REGFILE_BYPASS_EN
    exp = 8'h55;
`else
    exp = 8'h11;
`endif
    n_cmp++; if (r2dat !== exp) begin n_fail++; $display("FAIL collide_r2 got %h want %h", r2dat, exp); end
    idle(); r2add = 3'd0; tick();
    n_cmp++; if (r2dat !== exp) begin n_fail++; $display("FAIL r2_hold got %h want %h", r2dat, exp); end
  endtask

  task automatic test_pair_vs_byte();
    idle(); wrenb = 1; waddr = 3'd2; wdata = 8'h77; pwenb = 1; paddr = 2'd1; pdata = 16'hABCD; tick();
    n_cmp++; if (pdout !== 16'hABCD) begin n_fail++; $display("FAIL pair_wins got %h want ABCD", pdout); end
    idle(); wrenb = 1; waddr = 3'd5; wdata = 8'h66; pwenb = 1; paddr = 2'd1; pdata = 16'h4321; tick();
    n_cmp++; if (pdout !== 16'h4321) begin n_fail++; $display("FAIL pair_both got %h want 4321", pdout); end
    idle(); paddr = 2'd2; #1;
    n_cmp++; if (pdout[7:0] !== 8'h66) begin n_fail++; $display("FAIL byte_both got %h want 66", pdout[7:0]); end
  endtask

  task automatic test_reset_override();
    for (int i = 0; i < 8; i++) begin
      idle(); wrenb = 1; waddr = 3'(i); wdata = 8'(8'h31 + i); tick();
    end
    idle(); flenb = 1; flmask = 8'hFF; ifdat = 8'hC3; r1enb = 1; r1add = 3'd4; r2enb = 1; r2add = 3'd7;
    pwenb = 1; paddr = 2'd3; pdata = 16'h0000; tick();
    idle(); incenb = 1; paddr = 2'd3; pdata = 16'hFFFF; tick();
    idle(); rst = 0; wrenb = 1; waddr = 3'd1; wdata = 8'hEE; decenb = 1; flenb = 1; flmask = 8'hFF; ifdat = 8'hFF;
    r1enb = 1; r2enb = 1; tick();
    idle();
    for (int p = 0; p < 4; p++) begin
      paddr = 2'(p); #1;
      n_cmp++;
      if (pdout !== 16'h0000) begin n_fail++; $display("FAIL rstov_pair%0d got %h want 0000", p, pdout); end
    end
    n_cmp++; if (ofdat !== 8'h00) begin n_fail++; $display("FAIL rstov_flag got %h want 00", ofdat); end
    n_cmp++; if (r1dat !== 8'h00) begin n_fail++; $display("FAIL rstov_r1 got %h want 00", r1dat); end
    n_cmp++; if (r2dat !== 8'h00) begin n_fail++; $display("FAIL rstov_r2 got %h want 00", r2dat); end
    n_cmp++; if (pzero !== 1'b0) begin n_fail++; $display("FAIL rstov_pzero got %b want 0", pzero); end
    idle(); wrenb = 1; waddr = 3'd6; wdata = 8'h5A; tick();
    idle(); paddr = 2'd3; #1;
    n_cmp++; if (pdout !== 16'h5A00) begin n_fail++; $display("FAIL post_reset_write got %h want 5A00", pdout); end
  endtask

  task automatic test_random();
    logic [15:0] exp_p;
    for (int n = 0; n < 400; n++) begin
      rst    = ($urandom_range(0, 49) != 0);
      wrenb  = 1'($urandom);
      waddr  = 3'($urandom);
      wdata  = 8'($urandom);
      pwenb  = ($urandom_range(0, 3) == 0);
      incenb = 1'($urandom);
      decenb = 1'($urandom);
      paddr  = 2'($urandom);
      pdata  = ($urandom_range(0, 3) == 0) ? {15'h7FFF, 1'($urandom)} : 16'($urandom);
      flenb  = 1'($urandom);
      flmask = 8'($urandom);
      ifdat  = 8'($urandom);
      r1enb  = 1'($urandom);
      r2enb  = 1'($urandom);
      r1add  = 3'($urandom);
      r2add  = 3'($urandom);
      tick();
      exp_p = {m_regs[int'(paddr) * 2], m_regs[int'(paddr) * 2 + 1]};
      n_cmp++; if (pdout !== exp_p) begin n_fail++; $display("FAIL rnd_pdout[%0d] got %h want %h", n, pdout, exp_p); end
      n_cmp++; if (pzero !== m_pz) begin n_fail++; $display("FAIL rnd_pzero[%0d] got %b want %b", n, pzero, m_pz); end
      n_cmp++; if (ofdat !== m_flag) begin n_fail++; $display("FAIL rnd_flag[%0d] got %h want %h", n, ofdat, m_flag); end
      n_cmp++; if (r1dat !== m_r1) begin n_fail++; $display("FAIL rnd_r1[%0d] got %h want %h", n, r1dat, m_r1); end
      n_cmp++; if (r2dat !== m_r2) begin n_fail++; $display("FAIL rnd_r2[%0d] got %h want %h", n, r2dat, m_r2); end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_flag = 0; m_r1 = 0; m_r2 = 0; m_pz = 0;
    idle(); rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_byte_write();
    test_pair_inc();
    test_pair_dec();
    test_flags();
    test_read_collision();
    test_pair_vs_byte();
    test_reset_override();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_ext.md
REGFILE_EXT -- requirements
Module: regfile_ext

Interface
REQ-001 The block SHALL have parameter DATASIZE, default 8, register width in bits.
REQ-002 The block SHALL have parameter REGBIT, default 3, register address width; register count is 2**REGBIT, and REGBIT >= 1.
REQ-003 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1; reset is synchronous and active-low.
REQ-005 Port wrenb, input, 1: byte write enable.
REQ-006 Port waddr, input, REGBIT: byte write address.
REQ-007 Port wdata, input, DATASIZE: byte write data.
REQ-008 Port pwenb, input, 1: register-pair write enable.
REQ-009 Port incenb, input, 1: pair increment enable.
REQ-010 Port decenb, input, 1: pair decrement enable.
REQ-011 Port paddr, input, REGBIT-1: pair select; pair p is register 2p (high byte) plus register 2p+1 (low byte).
REQ-012 Port pdata, input, 2*DATASIZE: pair write data, formatted {high,low}.
REQ-013 Port pdout, output, 2*DATASIZE: combinational {reg[2p],reg[2p+1]} of the pair selected by paddr.
REQ-014 Port pzero, output, 1: registered pulse, high when the previous cycle's inc/dec result was zero.
REQ-015 Port flenb, input, 1: flag update enable.
REQ-016 Port flmask, input, DATASIZE: per-bit flag update mask.
REQ-017 Port ifdat, input, DATASIZE: flag input data.
REQ-018 Port ofdat, output, DATASIZE: flag register contents.
REQ-019 Ports r1enb/r2enb, input, 1 each: read port enables.
REQ-020 Ports r1add/r2add, input, REGBIT each: read addresses.
REQ-021 Ports r1dat/r2dat, output, DATASIZE each: registered read data.

Function
REQ-022 A byte write SHALL store wdata into reg[waddr] at the edge where wrenb=1.
REQ-023 Pair operations SHALL have priority pwenb > incenb > decenb; only the highest-priority asserted operation executes.
REQ-024 A pair write SHALL store pdata into the selected pair in one cycle.
REQ-025 Inc/dec SHALL treat the pair as a 2*DATASIZE unsigned value, wrap modulo 2**(2*DATASIZE), and carry/borrow across bytes within the same cycle.
REQ-026 When a byte write and a pair operation target the same register in one cycle, the pair operation SHALL win; otherwise both SHALL take effect.
REQ-027 pzero SHALL be 1 for exactly the cycle after an inc/dec whose result is all-zero, and 0 otherwise (including after pair writes).
REQ-028 A flag update SHALL compute flag <= (flag & ~flmask) | (ifdat & flmask).
REQ-029 rNdat SHALL load reg[rNadd] at each edge with rNenb=1 (latency 1) and SHALL hold its value while rNenb=0.
REQ-030 Without bypass, a read that coincides with a write to the same register SHALL return the pre-write value.

Reset
REQ-031 With rst=0 at an edge, all registers, the flag register, r1dat, r2dat and pzero SHALL become 0, overriding every enable in that cycle.
REQ-032 An operation in progress during reset SHALL be discarded; the block SHALL accept new operations at the first edge with rst=1.

Configuration
REQ-033 With macro REGFILE_BYPASS_EN defined, a read that coincides with a write to the same register SHALL return the post-write value of that same edge, resolved per REQ-023/026 (this covers byte writes, pair writes and inc/dec).
REQ-034 Without REGFILE_BYPASS_EN, the behaviour SHALL be as in REQ-030 and no forwarding logic SHALL be present.

Structure
REQ-035 Package regfile_pkg SHALL hold the default DATASIZE/REGBIT constants and the pair-operation encoding type (NONE/WRITE/INC/DEC).
REQ-036 Each storage element SHALL be an instance of sub-module register (width DATASIZE, synchronous active-low reset, load enable), generated in a block named reg_block.

Verification
REQ-037 Byte write 8'hAA to reg 0, r1enb=1, r1add=0 -> r1dat=8'hAA one cycle later; reg 1 unchanged at 8'h00.
REQ-038 Pair write 16'h12FF to pair 1, then incenb=1 -> pdout=16'h1300, pzero=0; repeat with 16'hFFFF -> pdout=16'h0000 and pzero=1 for one cycle.
REQ-039 Pair 0=16'h0000 with decenb=1 -> pdout=16'hFFFF; with pwenb and decenb both asserted, pwenb's pdata SHALL be loaded.
REQ-040 Flag=8'h00, then ifdat=8'hFF with flmask=8'h0F -> ofdat=8'h0F; then ifdat=8'h00 with flmask=8'h05 -> ofdat=8'h0A.
REQ-041 Reg 3=8'h11; same cycle wrenb (addr 3, 8'h55) and r2enb (addr 3) -> r2dat=8'h11 without REGFILE_BYPASS_EN, 8'h55 with it.
REQ-042 Load all registers and the flag, assert rst=0 together with wrenb=1 for one edge -> all registers, ofdat, r1dat, r2dat and pzero read 0.
